// File: rtl/adc_emulator.sv
// Purpose : synthetic 8-bit parallel ADC driven by the scope's ADC_CLK/ADC_nOE strobes;
//           produces deterministic sawtooth/triangle/square/constant samples.
// Latency : sample made on ADC clock edge k is on oAdcData one iClk after edge k+pPipeDepth-1.
// Backpressure: none; the scope paces conversions with iAdcClk, and nOE blanks the output only.
//
// Ports:
//   iClk       system clock, all logic on its rising edge
//   iRst       synchronous reset, active-high (wins over a simultaneous ADC edge)
//   iAdcClk    ADC clock from the scope (iClk-synchronous); rising edges convert
//   iAdcnOE    output enable, active-low; forces oAdcData to 0 and suppresses oDataValid
//   iWaveSel   0 sawtooth, 1 triangle, 2 square, 3 constant (sampled on ADC edges)
//   iStep      phase increment per ADC edge (sampled on ADC edges)
//   oAdcData   registered emulated sample
//   oDataValid one-iClk pulse when oAdcData carries a freshly pipelined sample
//
// Build option: define ADC_EMU_NOISE_EN to add 0..3 LSBs of LFSR dither (saturating).
module adc_emulator #(
  parameter int          pPhaseBits  = 16,
  parameter int          pPipeDepth  = 3,
  parameter logic [7:0]  pConstLevel = 8'h80
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iAdcClk,
  input  logic                  iAdcnOE,
  input  logic [1:0]            iWaveSel,
  input  logic [pPhaseBits-1:0] iStep,
  output logic [7:0]            oAdcData,
  output logic                  oDataValid
);

  localparam int             FW       = $clog2(pPipeDepth + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(pPipeDepth);

  logic                  rAdcClkPrev;
  logic                  wEdge;
  logic [pPhaseBits-1:0] phase;
  logic [FW-1:0]         fill;
  logic [FW-1:0]         fill_inc;
  logic [7:0]            pipe      [pPipeDepth];
  logic [7:0]            pipe_next [pPipeDepth];
  logic [7:0]            wave;
  logic [7:0]            tri_t;
  logic [7:0]            sample;

  assign wEdge = iAdcClk & ~rAdcClkPrev;

  // Waveform from the phase before this edge's increment.
  always_comb begin
    tri_t = phase[pPhaseBits-2 -: 8];
    wave  = 8'h00;
    case (iWaveSel)
      2'd0:    wave = phase[pPhaseBits-1 -: 8];
      2'd1:    wave = phase[pPhaseBits-1] ? ~tri_t : tri_t;
      2'd2:    wave = phase[pPhaseBits-1] ? 8'hFF : 8'h00;
      default: wave = pConstLevel;
    endcase
  end

`ifdef ADC_EMU_NOISE_EN
  logic [15:0] lfsr;
  logic [8:0]  noisy;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      lfsr <= 16'hACE1;
    end else if (wEdge) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_comb begin
    noisy  = {1'b0, wave} + {7'b0, lfsr[1:0]};
    sample = noisy[8] ? 8'hFF : noisy[7:0];
  end
`else
  assign sample = wave;
`endif

  // Fill counter saturates once the pipe holds real samples.
  assign fill_inc = (fill == FILL_MAX) ? fill : fill + FW'(1);

  // Next pipe contents; the output register loads the post-shift last stage so
  // that the valid pulse lines up with the sample it announces.
  always_comb begin
    for (int i = 0; i < pPipeDepth; i++) begin
      pipe_next[i] = pipe[i];
    end
    if (wEdge) begin
      pipe_next[0] = sample;
      for (int i = 1; i < pPipeDepth; i++) begin
        pipe_next[i] = pipe[i-1];
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rAdcClkPrev <= 1'b0;
      phase       <= '0;
      fill        <= '0;
      oAdcData    <= 8'h00;
      oDataValid  <= 1'b0;
      for (int i = 0; i < pPipeDepth; i++) begin
        pipe[i] <= 8'h00;
      end
    end else begin
      rAdcClkPrev <= iAdcClk;
      for (int i = 0; i < pPipeDepth; i++) begin
        pipe[i] <= pipe_next[i];
      end
      if (wEdge) begin
        phase <= phase + iStep;
        fill  <= fill_inc;
      end
      oAdcData   <= iAdcnOE ? 8'h00 : pipe_next[pPipeDepth-1];
      oDataValid <= wEdge & (fill_inc == FILL_MAX) & ~iAdcnOE;
    end
  end

endmodule

// File: tb/tb_adc_emulator.sv
// Purpose : randomized scoreboard bench for adc_emulator (default build, no dither).
// Latency : expected samples are queued at the iClk edge that should raise oDataValid.
// Backpressure: none; the monitor flags both unexpected and missing valid pulses.
module tb_adc_emulator;

  localparam int         PB = 16;
  localparam int         PD = 3;
  localparam logic [7:0] CL = 8'h80;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iAdcClk;
  logic        iAdcnOE;
  logic [1:0]  iWaveSel;
  logic [15:0] iStep;
  logic [7:0]  oAdcData;
  logic        oDataValid;

  adc_emulator #(.pPhaseBits(PB), .pPipeDepth(PD), .pConstLevel(CL)) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iAdcClk    (iAdcClk),
    .iAdcnOE    (iAdcnOE),
    .iWaveSel   (iWaveSel),
    .iStep      (iStep),
    .oAdcData   (oAdcData),
    .oDataValid (oDataValid)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase as an integer, samples in flight as a list.
  int exp_q[$];
  int inflight[$];
  int phase;
  bit prev_clk;
  bit last_noe;
  bit last_rst;
  bit started = 1'b0;

  function automatic int wave(int p, int sel);
    int half;
    int t;
    half = (p >> 15) & 1;
    t    = (p >> 7) & 255;
    case (sel)
      0:       return (p >> 8) & 255;
      1:       return half ? 255 - t : t;
      2:       return half ? 255 : 0;
      default: return int'(CL);
    endcase
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %02h, required %02h at %0t", name, act, req, $time);
    end
  endtask

  // One iClk cycle: drive inputs, let the DUT sample them, advance the model.
  task automatic cyc(bit clk, bit rst);
    iAdcClk = clk;
    iRst    = rst;
    @(posedge iClk);
    last_noe = iAdcnOE;
    last_rst = rst;
    if (rst) begin
      phase = 0;
      inflight.delete();
      prev_clk = 1'b0;
    end else begin
      if (clk && !prev_clk) begin
        inflight.push_back(wave(phase, int'(iWaveSel)));
        phase = (phase + int'(iStep)) % 65536;
        // A sample leaves the conversion pipe PD-1 edges after it was made.
        if (inflight.size() == PD) begin
          int s;
          s = inflight.pop_front();
          if (!iAdcnOE) exp_q.push_back(s);
        end
      end
      prev_clk = clk;
    end
    #1;
  endtask

  task automatic adc_edges(int n, int hi, int lo);
    for (int e = 0; e < n; e++) begin
      for (int h = 0; h < hi; h++) cyc(1'b1, 1'b0);
      for (int l = 0; l < lo; l++) cyc(1'b0, 1'b0);
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge iClk) begin
    if (started) begin
      if (last_rst) begin
        check("reset_data", int'(oAdcData), 0);
        check("reset_valid", int'(oDataValid), 0);
      end else if (last_noe) begin
        check("noe_data", int'(oAdcData), 0);
        check("noe_valid", int'(oDataValid), 0);
      end
      if (oDataValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got valid with data %02h, required no pulse at %0t", oAdcData, $time);
        end else begin
          check("sample", int'(oAdcData), exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL missing_valid: got no pulse, required data %02h at %0t", exp_q[0], $time);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] held;
    iAdcClk  = 1'b0;
    iAdcnOE  = 1'b0;
    iWaveSel = 2'd0;
    iStep    = 16'h0000;
    iRst     = 1'b1;
    prev_clk = 1'b0;
    phase    = 0;
    cyc(1'b0, 1'b1);
    started = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);

    // Sawtooth through a full wrap.
    iWaveSel = 2'd0;
    iStep    = 16'h0100;
    adc_edges(262, 2, 2);

    // Triangle, two full periods.
    iWaveSel = 2'd1;
    iStep    = 16'h2000;
    adc_edges(20, 2, 2);

    // Square, then constant selected between edges.
    iWaveSel = 2'd2;
    iStep    = 16'h4000;
    adc_edges(10, 2, 2);
    cyc(1'b1, 1'b0);
    iWaveSel = 2'd3;
    cyc(1'b0, 1'b0);
    adc_edges(8, 2, 2);

    // Output enable pulled high for 10 iClk mid-stream.
    iWaveSel = 2'd0;
    iStep    = 16'h0300;
    adc_edges(6, 2, 2);
    iAdcnOE = 1'b1;
    adc_edges(2, 3, 2);
    iAdcnOE = 1'b0;
    adc_edges(8, 2, 2);

    // Reset coincident with a rising ADC edge; phase restarts at 0.
    cyc(1'b1, 1'b1);
    adc_edges(6, 2, 2);

    // ADC clock stuck high: nothing may change.
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    held = oAdcData;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b0);
      if (i % 10 == 0) check("hold_data", int'(oAdcData), int'(held));
    end
    cyc(1'b0, 1'b0);

    // Random waveforms, steps, ADC clock shapes and nOE blips.
    for (int seg = 0; seg < 40; seg++) begin
      int hi;
      int lo;
      iWaveSel = 2'($urandom_range(3, 0));
      iStep    = ($urandom_range(1, 0) == 1) ? 16'($urandom) : 16'($urandom_range(1024, 0));
      hi       = $urandom_range(3, 1);
      lo       = $urandom_range(3, 1);
      for (int e = 0; e < $urandom_range(25, 5); e++) begin
        iAdcnOE = ($urandom_range(7, 0) == 0);
        adc_edges(1, hi, lo);
      end
      iAdcnOE = 1'b0;
      if ($urandom_range(9, 0) == 0) cyc(1'b0, 1'b1);
    end

    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d samples left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
